exception_commit_ctrl: RTL

EXCEPTION_COMMIT_CTRL -- requirements
Module: exception_commit_ctrl

---
 rtl/exception_commit_ctrl_pkg.sv | 16 +
 rtl/exception_commit_ctrl_if.sv | 16 +
 rtl/exception_commit_ctrl_ex_prio_encoder.sv | 21 ++
 rtl/exception_commit_ctrl.sv | 68 ++++++
 4 files changed

// File: rtl/exception_commit_ctrl_pkg.sv
// exception_commit_ctrl_pkg: cause encodings, flag bit positions and FSM states shared by the commit controller.
package exception_commit_ctrl_pkg;
   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_INE  = 6'h0D;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [8:0] ESUBCODE_NONE = 9'h000;
   localparam int FLAG_ADEF = 0;
   localparam int FLAG_INE  = 1;
   localparam int FLAG_SYS  = 2;
   localparam int FLAG_BRK  = 3;
   localparam int FLAG_ALE  = 4;
   typedef enum logic [1:0] {IDLE, COMMIT, REDIR} state_t;
endpackage

// File: rtl/exception_commit_ctrl_if.sv
// exception_commit_ctrl_if: writeback-stage handoff and fetch-redirect handshake.
interface exception_commit_ctrl_if;
   logic        ws_valid;
   logic        ws_ready;
   logic [31:0] ws_pc;
   logic [31:0] ws_vaddr;
   logic [4:0]  ws_ex_flags;
   logic        ws_ertn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   modport master (output ws_valid, ws_pc, ws_vaddr, ws_ex_flags, ws_ertn, redirect_ready,
                   input ws_ready, redirect_valid, redirect_pc);
   modport slave (input ws_valid, ws_pc, ws_vaddr, ws_ex_flags, ws_ertn, redirect_ready,
                  output ws_ready, redirect_valid, redirect_pc);
endinterface

// File: rtl/exception_commit_ctrl_ex_prio_encoder.sv
// ex_prio_encoder: picks the highest-priority pending cause, INT > ADEF > INE > SYS > BRK > ALE.
module ex_prio_encoder
   import exception_commit_ctrl_pkg::*;
(
   input  logic [4:0] flags,
   input  logic       has_int,
   output logic       valid,
   output logic [5:0] ecode,
   output logic [8:0] esubcode
);
   always_comb begin
      valid    = has_int | (|flags);
      esubcode = ESUBCODE_NONE;
      ecode    = has_int           ? ECODE_INT  :
                 flags[FLAG_ADEF]  ? ECODE_ADEF :
                 flags[FLAG_INE]   ? ECODE_INE  :
                 flags[FLAG_SYS]   ? ECODE_SYS  :
                 flags[FLAG_BRK]   ? ECODE_BRK  :
                 flags[FLAG_ALE]   ? ECODE_ALE  : ECODE_INT;
   end
endmodule

// File: rtl/exception_commit_ctrl.sv
// exception_commit_ctrl: commits exceptions/interrupts/ERTN from writeback, pulses the CSR file,
// flushes the pipe and holds a fetch redirect until it is accepted.
module exception_commit_ctrl
   import exception_commit_ctrl_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   exception_commit_ctrl_if.slave        ws,
   input  logic                          has_int,
   input  logic [31:0]                   ex_entry,
   input  logic [31:0]                   ex_ra,
   output logic                          wb_ex,
   output logic                          ertn_flush,
   output logic [5:0]                    wb_ecode,
   output logic [8:0]                    wb_esubcode,
   output logic [31:0]                   wb_pc,
   output logic [31:0]                   wb_vaddr,
   output logic                          flush_pipe
);
   state_t      state, next;
   logic        is_ex;
   logic        enc_valid;
   logic [5:0]  enc_ecode;
   logic [8:0]  enc_esubcode;
   logic        ev;
   ex_prio_encoder u_prio (
      .flags    (ws.ws_ex_flags),
      .has_int  (has_int),
      .valid    (enc_valid),
      .ecode    (enc_ecode),
      .esubcode (enc_esubcode)
   );
   assign ev = (state == IDLE) & ws.ws_valid & (enc_valid | ws.ws_ertn);
   always_comb begin
      next              = state;
      ws.ws_ready       = state == IDLE;
      ws.redirect_valid = state == REDIR;
      wb_ex             = (state == COMMIT) & is_ex;
      ertn_flush        = (state == COMMIT) & ~is_ex;
      flush_pipe        = state != IDLE;
      next              = state == IDLE   ? (ev ? COMMIT : IDLE) :
                          state == COMMIT ? REDIR :
                          ws.redirect_ready ? IDLE : REDIR;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         is_ex          <= 1'b0;
         wb_ecode       <= '0;
         wb_esubcode    <= '0;
         wb_pc          <= '0;
         wb_vaddr       <= '0;
         ws.redirect_pc <= '0;
      end else begin
         state <= next;
         if (ev) begin
            is_ex       <= enc_valid;
            wb_ecode    <= enc_ecode;
            wb_esubcode <= enc_esubcode;
            wb_pc       <= ws.ws_pc;
            // an instruction-fetch fault reports the PC itself as the bad address
            wb_vaddr    <= (enc_valid && enc_ecode == ECODE_ADEF && !has_int) ? ws.ws_pc : ws.ws_vaddr;
         end
         if (state == COMMIT)
            ws.redirect_pc <= is_ex ? ex_entry : ex_ra;
      end
   end
endmodule
